// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the von_neumann CPU with memory-wait watchdog and retire counter.
// Optional feature: define CU_ILLEGAL_TRAP_EN to send opcodes 7..E to FAULT instead of executing them as NOP.
module cpu_control_unit #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             REST,
  input  logic             RUN,
  input  logic [3:0]       IR_OPCODE,
  input  logic             ACC_ZERO,
  input  logic             MEM_ACK,
  output logic             MAR_SEL,
  output logic             MAR_LOAD,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             IR_LOAD,
  output logic             PC_INC,
  output logic             PC_LOAD,
  output logic             ACC_LOAD,
  output logic [1:0]       ALU_OP,
  output logic             HALTED,
  output logic             FAULT,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_F1    = 4'd1,
    S_F2    = 4'd2,
    S_F3    = 4'd3,
    S_DEC   = 4'd4,
    S_E1    = 4'd5,
    S_E2    = 4'd6,
    S_E3    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_HLT = 4'hF
  } opcode_t;

  state_t           state;
  state_t           next_state;
  opcode_t          op_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             retire;
  logic             wait_expired;

  // One more ACK-less cycle would make the wait count reach WAIT_LIMIT.
  assign wait_expired = (wait_cnt == 8'(WAIT_LIMIT - 1));

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:  if (RUN) next_state = S_F1;
      S_F1:    next_state = S_F2;
      S_F2: begin
        if (MEM_ACK)           next_state = S_F3;
        else if (wait_expired) next_state = S_FAULT;
      end
      S_F3:    next_state = S_DEC;
      S_DEC: begin
        case (opcode_t'(IR_OPCODE))
          OP_NOP, OP_JMP, OP_JZ: begin
            next_state = S_F1;
            retire     = 1'b1;
          end
          OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state = S_E1;
          OP_HLT: begin
            next_state = S_HALT;
            retire     = 1'b1;
          end
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            next_state = S_FAULT;
`else
            next_state = S_F1;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      S_E1:    next_state = S_E2;
      S_E2: begin
        if (MEM_ACK) begin
          if (op_q == OP_STA) begin
            next_state = S_F1;
            retire     = 1'b1;
          end else begin
            next_state = S_E3;
          end
        end else if (wait_expired) begin
          next_state = S_FAULT;
        end
      end
      S_E3: begin
        next_state = S_F1;
        retire     = 1'b1;
      end
      S_HALT:  next_state = S_HALT;
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!REST) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_DEC) op_q <= opcode_t'(IR_OPCODE);
      // Held at zero outside the memory-wait states, so it is already clear on entry.
      if ((state == S_F2 || state == S_E2) && !MEM_ACK) wait_cnt <= wait_cnt + 8'd1;
      else                                              wait_cnt <= '0;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    MAR_SEL  = 1'b0;
    MAR_LOAD = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    IR_LOAD  = 1'b0;
    PC_INC   = 1'b0;
    PC_LOAD  = 1'b0;
    ACC_LOAD = 1'b0;
    ALU_OP   = 2'b00;
    case (state)
      S_F1:  MAR_LOAD = 1'b1;
      S_F2:  MEM_RD = 1'b1;
      S_F3: begin
        IR_LOAD = 1'b1;
        PC_INC  = 1'b1;
      end
      S_DEC: PC_LOAD = (IR_OPCODE == OP_JMP) || ((IR_OPCODE == OP_JZ) && ACC_ZERO);
      S_E1: begin
        MAR_SEL  = 1'b1;
        MAR_LOAD = 1'b1;
      end
      S_E2: begin
        if (op_q == OP_STA) MEM_WR = 1'b1;
        else                MEM_RD = 1'b1;
      end
      S_E3: begin
        ACC_LOAD = 1'b1;
        case (op_q)
          OP_ADD:  ALU_OP = 2'b01;
          OP_SUB:  ALU_OP = 2'b10;
          default: ALU_OP = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign HALTED    = (state == S_HALT);
  assign FAULT     = (state == S_FAULT);
  assign STATE     = state;
  assign INSTR_CNT = instr_cnt;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: instruction-level model emits expected per-cycle outputs.
module tb_cpu_control_unit;

  localparam int unsigned WL = 4;
  localparam int unsigned CW = 4;

  localparam int ST_IDLE = 0, ST_F1 = 1, ST_F2 = 2, ST_F3 = 3, ST_DEC = 4;
  localparam int ST_E1 = 5, ST_E2 = 6, ST_E3 = 7, ST_HALT = 8, ST_FAULT = 9;

  logic          clk = 1'b0;
  logic          REST, RUN, ACC_ZERO, MEM_ACK;
  logic [3:0]    IR_OPCODE;
  logic          MAR_SEL, MAR_LOAD, MEM_RD, MEM_WR, IR_LOAD, PC_INC, PC_LOAD, ACC_LOAD;
  logic [1:0]    ALU_OP;
  logic          HALTED, FAULT;
  logic [3:0]    STATE;
  logic [CW-1:0] INSTR_CNT;

  always #5 clk = ~clk;

  cpu_control_unit #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .REST(REST), .RUN(RUN), .IR_OPCODE(IR_OPCODE), .ACC_ZERO(ACC_ZERO),
    .MEM_ACK(MEM_ACK), .MAR_SEL(MAR_SEL), .MAR_LOAD(MAR_LOAD), .MEM_RD(MEM_RD),
    .MEM_WR(MEM_WR), .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
    .ACC_LOAD(ACC_LOAD), .ALU_OP(ALU_OP), .HALTED(HALTED), .FAULT(FAULT),
    .STATE(STATE), .INSTR_CNT(INSTR_CNT)
  );

  typedef struct packed {
    logic [3:0]    st;
    logic          mar_sel, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load;
    logic [1:0]    alu_op;
    logic          halted, fault;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t        act;
  obs_t        exp_q[$];
  int          checks = 0;
  int          fails  = 0;
  int unsigned cnt_m  = 0;

  assign act = {STATE, MAR_SEL, MAR_LOAD, MEM_RD, MEM_WR, IR_LOAD, PC_INC, PC_LOAD,
                ACC_LOAD, ALU_OP, HALTED, FAULT, INSTR_CNT};

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e;
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          fails++;
          $display("FAIL cycle_state%0d t=%0t actual=%h required=%h", e.st, $time, act, e);
        end
      end
    end
  end

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input int st);
    obs_t e;
    e     = '0;
    e.st  = 4'(st);
    e.cnt = CW'(cnt_m);
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic run, input logic [3:0] op, input logic az,
                     input logic ack, input obs_t e, input bit chk);
    @(posedge clk);
    #1;
    REST = rst; RUN = run; IR_OPCODE = op; ACC_ZERO = az; MEM_ACK = ack;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input logic run);
    cyc(1'b1, run, rop(), rb(), rb(), blank(ST_IDLE), 1'b1);
  endtask

  // Terminal-state cycles; the last one applies reset so the next cycle is IDLE.
  task automatic terminal_cycles(input int st, input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(st);
      if (st == ST_HALT) e.halted = 1'b1;
      else               e.fault  = 1'b1;
      cyc((i == n - 1) ? 1'b0 : 1'b1, rb(), rop(), rb(), rb(), e, 1'b1);
    end
    cnt_m = 0;
    idle_cycle(1'b0);
    idle_cycle(1'b1);
  endtask

  // Memory wait: ACK arrives after w idle cycles; WL ACK-less cycles end in FAULT (outcome 2).
  task automatic mem_phase(input int st, input bit wr, input int w, input bit rst_first,
                           output int outcome);
    obs_t e;
    outcome = 0;
    for (int i = 0; i <= w; i++) begin
      if (i == int'(WL)) begin
        outcome = 2;
        return;
      end
      e = blank(st);
      if (wr) e.mem_wr = 1'b1;
      else    e.mem_rd = 1'b1;
      if (rst_first) begin
        cyc(1'b0, 1'b0, rop(), rb(), 1'b0, e, 1'b1);
        cnt_m   = 0;
        outcome = 3;
        return;
      end
      cyc(1'b1, rb(), rop(), rb(), (i == w), e, 1'b1);
    end
  endtask

  // outcome: 0 back to fetch, 1 halted, 2 faulted, 3 reset applied in E2
  task automatic do_instr(input logic [3:0] op, input logic az, input int wf, input int we,
                          input bit rst_e2, output int outcome);
    obs_t e;
    outcome = 0;
    e = blank(ST_F1); e.mar_load = 1'b1;
    cyc(1'b1, rb(), rop(), rb(), rb(), e, 1'b1);
    mem_phase(ST_F2, 1'b0, wf, 1'b0, outcome);
    if (outcome != 0) return;
    e = blank(ST_F3); e.ir_load = 1'b1; e.pc_inc = 1'b1;
    cyc(1'b1, rb(), rop(), rb(), rb(), e, 1'b1);
    e = blank(ST_DEC); e.pc_load = (op == 4'h5) || (op == 4'h6 && az);
    cyc(1'b1, rb(), op, az, rb(), e, 1'b1);
    if (op == 4'h0 || op == 4'h5 || op == 4'h6) begin
      cnt_m++;
      return;
    end
    if (op == 4'hF) begin
      cnt_m++;
      outcome = 1;
      return;
    end
    if (op > 4'h4) begin
`ifdef CU_ILLEGAL_TRAP_EN
      outcome = 2;
`else
      cnt_m++;
`endif
      return;
    end
    e = blank(ST_E1); e.mar_sel = 1'b1; e.mar_load = 1'b1;
    cyc(1'b1, rb(), rop(), rb(), rb(), e, 1'b1);
    mem_phase(ST_E2, (op == 4'h4), we, rst_e2, outcome);
    if (outcome != 0) return;
    if (op == 4'h4) begin
      cnt_m++;
      return;
    end
    e = blank(ST_E3); e.acc_load = 1'b1;
    e.alu_op = (op == 4'h2) ? 2'b01 : (op == 4'h3) ? 2'b10 : 2'b00;
    cyc(1'b1, rb(), rop(), rb(), rb(), e, 1'b1);
    cnt_m++;
  endtask

  task automatic issue(input logic [3:0] op, input logic az, input int wf, input int we);
    int outcome;
    do_instr(op, az, wf, we, 1'b0, outcome);
    if (outcome == 1) terminal_cycles(ST_HALT, 4);
    else if (outcome == 2) terminal_cycles(ST_FAULT, 4);
  endtask

  initial begin
    int outcome;
    logic [3:0] op;
    REST = 1'b0; RUN = 1'b0; IR_OPCODE = '0; ACC_ZERO = 1'b0; MEM_ACK = 1'b0;
    cyc(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, blank(ST_IDLE), 1'b0);
    cyc(1'b0, 1'b1, rop(), rb(), rb(), blank(ST_IDLE), 1'b1);
    repeat (3) idle_cycle(1'b0);
    idle_cycle(1'b1);

    issue(4'h1, 1'b0, 0, 0);          // LDA, zero-wait memory
    issue(4'h4, 1'b0, 0, 2);          // STA, two wait cycles before ACK
    issue(4'h6, 1'b1, 1, 0);          // JZ taken
    issue(4'h6, 1'b0, 0, 0);          // JZ not taken
    issue(4'h5, 1'b0, 0, 0);
    issue(4'h0, 1'b0, 2, 0);
    issue(4'h2, 1'b0, WL - 1, WL - 1); // ACK on the last permitted cycle
    issue(4'h3, 1'b1, 0, 1);
    issue(4'hA, 1'b0, 0, 0);          // illegal opcode

    repeat (40) begin
`ifdef CU_ILLEGAL_TRAP_EN
      op = 4'($urandom_range(0, 6));
`else
      op = 4'($urandom_range(0, 14));
`endif
      issue(op, rb(), $urandom_range(0, WL - 1), $urandom_range(0, WL - 1));
    end

    issue(4'hF, 1'b0, 0, 0);          // HLT
    issue(4'h1, 1'b0, WL + 2, 0);     // fetch never acknowledged
    issue(4'h4, 1'b0, 0, WL + 1);     // store never acknowledged

    do_instr(4'h2, 1'b0, 0, 0, 1'b1, outcome); // reset during E2 of ADD
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    issue(4'h1, 1'b0, 0, 0);
    issue(4'h0, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
